// File: rtl/excess3_pkg.sv
// Shared excess-3 constants and the word-decoder state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Used by both the encoder and decoder sides, so the offset lives here once.
package excess3_pkg;

    localparam logic [3:0] E3_OFFSET = 4'd3;
    localparam logic [3:0] E3_MIN    = 4'h3;
    localparam logic [3:0] E3_MAX    = 4'hC;
    localparam logic [3:0] BCD_BAD   = 4'hF;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } e3_state_t;

endpackage

// File: rtl/excess3_digit_decode.sv
// Single-digit excess-3 to BCD decoder with illegal-code detection.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
//
// Ports:
//   e3      : excess-3 coded digit
//   bcd     : decoded BCD digit, forced to BCD_BAD for illegal codes
//   illegal : high for codes outside E3_MIN..E3_MAX
module excess3_digit_decode
    import excess3_pkg::*;
(
    input  logic [3:0] e3,
    output logic [3:0] bcd,
    output logic       illegal
);

    always_comb begin
        illegal = (e3 < E3_MIN) || (e3 > E3_MAX);
        // Illegal codes get a recognisable non-decimal nibble so a bad digit
        // stays visible in the packed word, not just in the sticky flag.
        bcd     = illegal ? BCD_BAD : (e3 - E3_OFFSET);
    end

endmodule

// File: rtl/excess3_to_bcd_word.sv
// Streams excess-3 digits (MSD first) into a right-justified packed BCD word.
// Latency: out_valid rises on the edge after the final digit is accepted.
// Backpressure: in_ready drops while a finished word waits for out_ready.
//
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   in_valid/in_ready  : digit handshake; in_e3 digit, in_last ends the word
//   out_valid/out_ready: word handshake
//   out_bcd            : packed BCD word, digit 0 (last received) in [3:0]
//   out_ndig           : digits in this word (1..NDIGITS)
//   out_err            : some digit in this word was an illegal excess-3 code
module excess3_to_bcd_word
    import excess3_pkg::*;
#(
    parameter  int NDIGITS = 4,
    localparam int CW      = $clog2(NDIGITS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_e3,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NDIGITS-1:0]   out_bcd,
    output logic [CW-1:0]          out_ndig,
    output logic                   out_err
);

    localparam int WW = 4 * NDIGITS;

    e3_state_t         state_q, state_d;
    logic [WW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [WW-1:0]     out_bcd_q, out_bcd_d;
    logic [CW-1:0]     out_ndig_q, out_ndig_d;
    logic              out_err_q, out_err_d;

    logic [3:0]        dec_bcd;
    logic              dec_illegal;
    logic [WW-1:0]     acc_shift;

    excess3_digit_decode u_decode (
        .e3      (in_e3),
        .bcd     (dec_bcd),
        .illegal (dec_illegal)
    );

    // New digit enters at the bottom so a short word ends up right-justified
    // with zero upper nibbles (the accumulator starts cleared).
    assign acc_shift = (acc_q << 4) | WW'(dec_bcd);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        out_bcd_d  = out_bcd_q;
        out_ndig_d = out_ndig_q;
        out_err_d  = out_err_q;

        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    acc_d = acc_shift;
                    cnt_d = cnt_q + CW'(1);
                    err_d = err_q | dec_illegal;
                    // A full word closes itself whether or not in_last is set.
                    if (in_last || (cnt_q == CW'(NDIGITS - 1))) begin
                        out_bcd_d  = acc_shift;
                        out_ndig_d = cnt_q + CW'(1);
                        out_err_d  = err_q | dec_illegal;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                // Output fields stay as-is after the handshake; only
                // out_valid (the state) drops.
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            acc_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            out_bcd_q  <= '0;
            out_ndig_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            out_bcd_q  <= out_bcd_d;
            out_ndig_q <= out_ndig_d;
            out_err_q  <= out_err_d;
        end
    end

    // Handshake flags decode straight from the state flop: no in-to-out path.
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign out_bcd   = out_bcd_q;
    assign out_ndig  = out_ndig_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_excess3_to_bcd_word.sv
// Scoreboard bench for excess3_to_bcd_word (NDIGITS=4).
// Latency: n/a.
// Backpressure: exercised by holding out_ready low.
module tb_excess3_to_bcd_word;

    typedef struct packed {
        logic [15:0] bcd;
        logic [2:0]  ndig;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_e3;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic [2:0]  out_ndig;
    logic        out_err;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    excess3_to_bcd_word #(.NDIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_e3     (in_e3),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_ndig  (out_ndig),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: a word is consumed at the posedge following a negedge where
    // both out_valid and out_ready are high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got bcd 0x%0h with empty scoreboard", out_bcd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("word_bcd",  32'(out_bcd),  32'(e.bcd));
                check("word_ndig", 32'(out_ndig), 32'(e.ndig));
                check("word_err",  32'(out_err),  32'(e.err));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the digit is taken.
    task automatic send(input logic [3:0] e3, input logic last);
        int n;
        in_valid = 1'b1;
        in_e3    = e3;
        in_last  = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready 0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] sweep_exp [16];
        logic [3:0] v;
        int n;
        sweep_exp = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                      4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF, 4'hF, 4'hF};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_e3     = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_bcd",   32'(out_bcd),   0);
        check("rst_out_ndig",  32'(out_ndig),  0);
        check("rst_out_err",   32'(out_err),   0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready",  32'(in_ready),  1);

        // Full word back-to-back, 1-cycle latency, in_ready low one cycle.
        exp_q.push_back('{16'h1234, 3'd4, 1'b0});
        send(4'h4, 1'b0);
        send(4'h5, 1'b0);
        send(4'h6, 1'b0);
        send(4'h7, 1'b1);
        check("lat_out_valid", 32'(out_valid), 1);
        check("lat_in_ready",  32'(in_ready),  0);
        tick();
        check("post_out_valid", 32'(out_valid), 0);
        check("post_in_ready",  32'(in_ready),  1);

        // Short word.
        exp_q.push_back('{16'h0090, 3'd2, 1'b0});
        send(4'hC, 1'b0);
        send(4'h3, 1'b1);

        // Illegal codes, then confirm the flag does not leak.
        exp_q.push_back('{16'h2FF9, 3'd4, 1'b1});
        send(4'h5, 1'b0);
        send(4'hD, 1'b0);
        send(4'h2, 1'b0);
        send(4'hC, 1'b1);
        exp_q.push_back('{16'h0000, 3'd1, 1'b0});
        send(4'h3, 1'b1);

        // Auto-close at NDIGITS without in_last.
        exp_q.push_back('{16'h9876, 3'd4, 1'b0});
        send(4'hC, 1'b0);
        send(4'hB, 1'b0);
        send(4'hA, 1'b0);
        send(4'h9, 1'b0);
        tick();
        tick();

        // Backpressure: hold the word 5 cycles with stray in_valid pulses.
        out_ready = 1'b0;
        exp_q.push_back('{16'h1234, 3'd4, 1'b0});
        send(4'h4, 1'b0);
        send(4'h5, 1'b0);
        send(4'h6, 1'b0);
        send(4'h7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_e3    = 4'h8;
            in_last  = 1'b1;
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_bcd",   32'(out_bcd),   32'h1234);
            check("bp_out_ndig",  32'(out_ndig),  4);
            check("bp_in_ready",  32'(in_ready),  0);
            tick();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 0);

        // Reset mid-word discards the partial digits.
        send(4'h4, 1'b0);
        send(4'h5, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.push_back('{16'h0006, 3'd1, 1'b0});
        send(4'h9, 1'b1);
        tick();

        // Reset during HOLD: no word delivered, outputs back to reset values.
        out_ready = 1'b0;
        send(4'h8, 1'b1);
        check("hold_pre_rst_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        tick();
        check("hold_rst_valid", 32'(out_valid), 0);
        check("hold_rst_bcd",   32'(out_bcd),   0);
        check("hold_rst_ndig",  32'(out_ndig),  0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();

        // Every code as a single-digit word.
        for (int k = 0; k < 16; k++) begin
            v = 4'(k);
            exp_q.push_back('{{12'h000, sweep_exp[k]}, 3'd1, (k < 3 || k > 12)});
            send(v, 1'b1);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
